// File: rtl/flu_sched_pkg.sv
// Shared types and helpers for the FLU packet scheduler: FSM state, log2 and
// the test that decides whether a word leaves a packet open after it.
package flu_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] sop_byte(input logic [15:0] sop_pos, input int shift);
        return sop_pos << shift;
    endfunction

    // A SOP that starts after the EOP byte means a second packet begins in the same word.
    function automatic logic open_after(input logic sop, input logic eop,
                                        input logic [15:0] sop_pos, input logic [15:0] eop_pos,
                                        input int shift);
        return (sop && !eop) ||
               (sop && eop && (sop_byte(sop_pos, shift) > eop_pos)) ||
               (!sop && !eop);
    endfunction

endpackage

// File: rtl/flu_pfifo_sched_rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant wins,
// wrapping around, with last_grant itself lowest priority.
module rr_arbiter
    import flu_sched_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int GW    = log2(PORTS)
)(
    input  logic [PORTS-1:0] req,
    input  logic [GW-1:0]    last_grant,
    output logic [GW-1:0]    grant,
    output logic             valid
);

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        // Walk from farthest to nearest so the nearest requester is written last.
        for (int k = PORTS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % PORTS;
            if (req[idx[GW-1:0]]) begin
                grant = idx[GW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flu_pfifo_sched.sv
// Packet-granular round-robin merge of PORTS FLU streams onto one FLU output.
// Grant is taken at packet start and held until a closing word is transferred.
module flu_pfifo_sched
    import flu_sched_pkg::*;
#(
    parameter int PORTS         = 4,
    parameter int DATA_WIDTH    = 512,
    parameter int SOP_POS_WIDTH = 3,
    parameter int EOP_POS_WIDTH = log2(DATA_WIDTH / 8)
)(
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [PORTS*DATA_WIDTH-1:0]       RX_DATA,
    input  logic [PORTS*SOP_POS_WIDTH-1:0]    RX_SOP_POS,
    input  logic [PORTS*EOP_POS_WIDTH-1:0]    RX_EOP_POS,
    input  logic [PORTS-1:0]                  RX_SOP,
    input  logic [PORTS-1:0]                  RX_EOP,
    input  logic [PORTS-1:0]                  RX_SRC_RDY,
    output logic [PORTS-1:0]                  RX_DST_RDY,
    input  logic [PORTS-1:0]                  PORT_EN,
    output logic [DATA_WIDTH-1:0]             TX_DATA,
    output logic [SOP_POS_WIDTH-1:0]          TX_SOP_POS,
    output logic [EOP_POS_WIDTH-1:0]          TX_EOP_POS,
    output logic                              TX_SOP,
    output logic                              TX_EOP,
    output logic                              TX_SRC_RDY,
    input  logic                              TX_DST_RDY,
    output logic [log2(PORTS)-1:0]            GRANT,
    output logic                              BUSY
);

    localparam int GW        = log2(PORTS);
    localparam int SOP_SHIFT = EOP_POS_WIDTH - SOP_POS_WIDTH;

    state_t                   state;
    state_t                   state_next;
    logic [GW-1:0]            grant_q;
    logic [GW-1:0]            last_grant_q;
    logic [GW-1:0]            arb_grant;
    logic                     arb_valid;
    logic [PORTS-1:0]         req;
    logic                     sel_src_rdy;
    logic                     sel_sop;
    logic                     sel_eop;
    logic [SOP_POS_WIDTH-1:0] sel_sop_pos;
    logic [EOP_POS_WIDTH-1:0] sel_eop_pos;
    logic                     closing;
    logic                     xfer_close;

    assign req = RX_SRC_RDY & RX_SOP & PORT_EN;

    rr_arbiter #(.PORTS(PORTS), .GW(GW)) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // Zero-latency FLU mux steered by the registered grant.
    assign sel_src_rdy = RX_SRC_RDY[grant_q];
    assign sel_sop     = RX_SOP[grant_q];
    assign sel_eop     = RX_EOP[grant_q];
    assign sel_sop_pos = RX_SOP_POS[int'(grant_q)*SOP_POS_WIDTH +: SOP_POS_WIDTH];
    assign sel_eop_pos = RX_EOP_POS[int'(grant_q)*EOP_POS_WIDTH +: EOP_POS_WIDTH];
    assign TX_DATA     = RX_DATA[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign TX_SOP_POS  = sel_sop_pos;
    assign TX_EOP_POS  = sel_eop_pos;
    assign GRANT       = grant_q;

    assign closing    = !open_after(sel_sop, sel_eop, 16'(sel_sop_pos), 16'(sel_eop_pos), SOP_SHIFT);
    assign xfer_close = (state == LOCKED) && sel_src_rdy && TX_DST_RDY && closing;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(PORTS - 1);
        end else begin
            state <= state_next;
            if (state == IDLE && arb_valid) grant_q <= arb_grant;
            if (xfer_close) last_grant_q <= grant_q;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arb_valid) state_next = LOCKED;
            LOCKED:  if (xfer_close) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        BUSY       = (state == LOCKED);
        TX_SRC_RDY = 1'b0;
        TX_SOP     = 1'b0;
        TX_EOP     = 1'b0;
        RX_DST_RDY = '0;
        if (state == LOCKED) begin
            TX_SRC_RDY          = sel_src_rdy;
            TX_SOP              = sel_sop;
            TX_EOP              = sel_eop;
            RX_DST_RDY[grant_q] = TX_DST_RDY;
        end
    end

endmodule

// File: tb/tb_flu_pfifo_sched.sv
// Directed bench for flu_pfifo_sched: a per-cycle vector table for the FSM and
// handshakes, then packet sequences driven from per-port word stores.
module tb_flu_pfifo_sched;

    localparam int P   = 4;
    localparam int DW  = 512;
    localparam int SPW = 3;
    localparam int EPW = 6;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [2:0]  sop_pos;
        logic [5:0]  eop_pos;
        logic [31:0] tag;
    } word_t;

    typedef struct packed {
        logic [1:0] port;
        word_t      w;
    } exp_t;

    typedef struct {
        logic [3:0] src;
        logic [3:0] sop;
        logic [3:0] eop;
        logic [3:0] en;
        logic       dst;
        logic       rst;
        logic [9:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [P*DW-1:0]  rx_data;
    logic [P*SPW-1:0] rx_sop_pos;
    logic [P*EPW-1:0] rx_eop_pos;
    logic [P-1:0]     rx_sop, rx_eop, rx_src_rdy, rx_dst_rdy, port_en;
    logic [DW-1:0]    tx_data;
    logic [SPW-1:0]   tx_sop_pos;
    logic [EPW-1:0]   tx_eop_pos;
    logic             tx_sop, tx_eop, tx_src_rdy, tx_dst_rdy;
    logic [1:0]       grant;
    logic             busy;

    int    checks = 0;
    int    errors = 0;
    word_t mem [P][16];
    int    head [P];
    int    cnt  [P];
    exp_t  expq [$];
    int    nobs;
    logic  mirror_on;
    vec_t  tbl [23];
    int    used;

    always #5 clk = ~clk;

    flu_pfifo_sched #(.PORTS(P), .DATA_WIDTH(DW), .SOP_POS_WIDTH(SPW), .EOP_POS_WIDTH(EPW)) dut (
        .CLK(clk), .RESET(rst), .RX_DATA(rx_data), .RX_SOP_POS(rx_sop_pos), .RX_EOP_POS(rx_eop_pos),
        .RX_SOP(rx_sop), .RX_EOP(rx_eop), .RX_SRC_RDY(rx_src_rdy), .RX_DST_RDY(rx_dst_rdy),
        .PORT_EN(port_en), .TX_DATA(tx_data), .TX_SOP_POS(tx_sop_pos), .TX_EOP_POS(tx_eop_pos),
        .TX_SOP(tx_sop), .TX_EOP(tx_eop), .TX_SRC_RDY(tx_src_rdy), .TX_DST_RDY(tx_dst_rdy),
        .GRANT(grant), .BUSY(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic word_t mk(input logic sop, input logic eop, input logic [2:0] sp,
                                 input logic [5:0] ep, input logic [31:0] tag);
        word_t w;
        w.sop = sop; w.eop = eop; w.sop_pos = sp; w.eop_pos = ep; w.tag = tag;
        return w;
    endfunction

    task automatic load(input int p, input word_t w);
        mem[p][cnt[p]] = w;
        cnt[p]++;
    endtask

    task automatic load_pkt(input int p, input int n, input int pkt);
        for (int k = 0; k < n; k++)
            load(p, mk(k == 0, k == n - 1, 3'd0, (k == n - 1) ? 6'd63 : 6'd0,
                       {8'(p), 8'(pkt), 16'(k)}));
    endtask

    task automatic expect_words(input int p, input int from, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.port = 2'(p);
            e.w    = mem[p][from + k];
            expq.push_back(e);
        end
    endtask

    task automatic drive_srcs();
        word_t w;
        for (int i = 0; i < P; i++) begin
            w = '0;
            rx_src_rdy[i] = 1'b0;
            if (head[i] < cnt[i]) begin
                w = mem[i][head[i]];
                rx_src_rdy[i] = 1'b1;
            end
            rx_sop[i] = w.sop;
            rx_eop[i] = w.eop;
            rx_sop_pos[i*SPW +: SPW] = w.sop_pos;
            rx_eop_pos[i*EPW +: EPW] = w.eop_pos;
            rx_data[i*DW +: DW]      = {16{w.tag}};
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < P; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
        end
        drive_srcs();
    endtask

    task automatic reset_all();
        rst = 1'b1;
        expq.delete();
        nobs = 0;
        clear_srcs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock: observe at the falling edge, advance sources after the rising edge.
    task automatic cyc();
        logic [P-1:0] fire;
        exp_t e;
        @(negedge clk);
        fire = rx_dst_rdy & rx_src_rdy;
        if (mirror_on && nobs < 5) chk("rx_dst_rdy_mirror", 64'(rx_dst_rdy), 64'({tx_dst_rdy, 3'b000}));
        if (tx_src_rdy && tx_dst_rdy) begin
            if (nobs < expq.size()) begin
                e = expq[nobs];
                chk($sformatf("grant[%0d]", nobs), 64'(grant), 64'(e.port));
                chk($sformatf("tx_sop[%0d]", nobs), 64'(tx_sop), 64'(e.w.sop));
                chk($sformatf("tx_eop[%0d]", nobs), 64'(tx_eop), 64'(e.w.eop));
                chk($sformatf("tx_sop_pos[%0d]", nobs), 64'(tx_sop_pos), 64'(e.w.sop_pos));
                chk($sformatf("tx_eop_pos[%0d]", nobs), 64'(tx_eop_pos), 64'(e.w.eop_pos));
                checks++;
                if (tx_data !== {16{e.w.tag}}) begin
                    errors++;
                    $display("FAIL tx_data[%0d]: got %h, expected %h", nobs, tx_data, {16{e.w.tag}});
                end
            end else begin
                checks++;
                errors++;
                $display("FAIL extra_transfer: got tag %h, expected no transfer", tx_data[31:0]);
            end
            nobs++;
        end
        @(posedge clk); #1;
        for (int i = 0; i < P; i++) if (fire[i]) head[i]++;
        drive_srcs();
    endtask

    task automatic run(input string name, input int budget, output int n_cyc);
        n_cyc = 0;
        while (nobs < expq.size() && n_cyc < budget) begin
            cyc();
            n_cyc++;
        end
        chk({name, "_transfers"}, 64'(nobs), 64'(expq.size()));
    endtask

    initial begin
        rst = 1'b1; rx_data = '0; rx_sop_pos = '0; rx_eop_pos = '0;
        rx_sop = '0; rx_eop = '0; rx_src_rdy = '0; port_en = 4'b1111;
        tx_dst_rdy = 1'b1; mirror_on = 1'b0; nobs = 0;

        //             src      sop      eop      en       dst   rst   {txs,busy,g[1:0],rxd[3:0],tsop,teop}
        tbl[0]  = '{4'b0001, 4'b0001, 4'b0001, 4'b1111, 1'b1, 1'b0, 10'b0_0_00_0000_0_0};
        tbl[1]  = '{4'b0001, 4'b0001, 4'b0001, 4'b1111, 1'b1, 1'b0, 10'b1_1_00_0001_1_1};
        tbl[2]  = '{4'b0011, 4'b0011, 4'b0011, 4'b1111, 1'b1, 1'b0, 10'b0_0_00_0000_0_0};
        tbl[3]  = '{4'b0011, 4'b0011, 4'b0011, 4'b1111, 1'b0, 1'b0, 10'b1_1_01_0000_1_1};
        tbl[4]  = '{4'b0011, 4'b0011, 4'b0011, 4'b1111, 1'b1, 1'b0, 10'b1_1_01_0010_1_1};
        tbl[5]  = '{4'b0011, 4'b0011, 4'b0011, 4'b1111, 1'b1, 1'b0, 10'b0_0_01_0000_0_0};
        tbl[6]  = '{4'b0011, 4'b0011, 4'b0011, 4'b1111, 1'b1, 1'b0, 10'b1_1_00_0001_1_1};
        tbl[7]  = '{4'b0011, 4'b0011, 4'b0011, 4'b1101, 1'b1, 1'b0, 10'b0_0_00_0000_0_0};
        tbl[8]  = '{4'b0011, 4'b0011, 4'b0011, 4'b1101, 1'b1, 1'b0, 10'b1_1_00_0001_1_1};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1101, 1'b1, 1'b0, 10'b0_0_00_0000_0_0};
        tbl[10] = '{4'b1000, 4'b1000, 4'b0000, 4'b1111, 1'b1, 1'b0, 10'b0_0_00_0000_0_0};
        tbl[11] = '{4'b1000, 4'b1000, 4'b0000, 4'b1111, 1'b1, 1'b0, 10'b1_1_11_1000_1_0};
        tbl[12] = '{4'b1001, 4'b0001, 4'b1001, 4'b1111, 1'b1, 1'b0, 10'b1_1_11_1000_0_1};
        tbl[13] = '{4'b1001, 4'b0001, 4'b1001, 4'b1111, 1'b1, 1'b0, 10'b0_0_11_0000_0_0};
        tbl[14] = '{4'b1001, 4'b0001, 4'b1001, 4'b1111, 1'b1, 1'b0, 10'b1_1_00_0001_1_1};
        tbl[15] = '{4'b1000, 4'b0000, 4'b1000, 4'b1111, 1'b1, 1'b0, 10'b0_0_00_0000_0_0};
        tbl[16] = '{4'b1000, 4'b0000, 4'b1000, 4'b1111, 1'b1, 1'b0, 10'b0_0_00_0000_0_0};
        tbl[17] = '{4'b0100, 4'b0100, 4'b0000, 4'b1111, 1'b1, 1'b0, 10'b0_0_00_0000_0_0};
        tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0, 10'b0_1_10_0100_0_0};
        tbl[19] = '{4'b0100, 4'b0000, 4'b0100, 4'b1111, 1'b1, 1'b0, 10'b1_1_10_0100_0_1};
        tbl[20] = '{4'b0001, 4'b0001, 4'b0001, 4'b1111, 1'b1, 1'b1, 10'b0_0_10_0000_0_0};
        tbl[21] = '{4'b0010, 4'b0010, 4'b0010, 4'b1111, 1'b1, 1'b0, 10'b0_0_00_0000_0_0};
        tbl[22] = '{4'b0010, 4'b0010, 4'b0010, 4'b1111, 1'b1, 1'b0, 10'b1_1_01_0010_1_1};

        // Reset, then 20 idle cycles.
        reset_all();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("idle_c%0d", c), 64'({tx_src_rdy, busy, grant}), 64'd0);
            @(posedge clk); #1;
        end

        // Per-cycle vector table (positions all zero, so SOP&EOP closes).
        for (int i = 0; i < 23; i++) begin
            rx_src_rdy = tbl[i].src; rx_sop = tbl[i].sop; rx_eop = tbl[i].eop;
            port_en = tbl[i].en; tx_dst_rdy = tbl[i].dst; rst = tbl[i].rst;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                64'({tx_src_rdy, busy, grant, rx_dst_rdy, tx_sop, tx_eop}), 64'(tbl[i].exp));
            @(posedge clk); #1;
        end
        rst = 1'b0; port_en = 4'b1111; tx_dst_rdy = 1'b1;

        // Four 3-word packets: order 0,1,2,3 with one idle cycle each.
        reset_all();
        for (int p = 0; p < P; p++) load_pkt(p, 3, 0);
        for (int p = 0; p < P; p++) expect_words(p, 0, 3);
        drive_srcs();
        run("rr4", 40, used);
        chk("rr4_cycles", 64'(used), 64'd16);

        // Trailing SOP (sop_byte 16 > EOP_POS 10) keeps the grant on port 1.
        reset_all();
        load(1, mk(1'b1, 1'b0, 3'd0, 6'd0,  32'h0101_0000));
        load(1, mk(1'b1, 1'b1, 3'd2, 6'd10, 32'h0101_0001));
        load(1, mk(1'b0, 1'b1, 3'd0, 6'd63, 32'h0101_0002));
        load(2, mk(1'b1, 1'b1, 3'd0, 6'd63, 32'h0202_0000));
        expect_words(1, 0, 3);
        expect_words(2, 0, 1);
        drive_srcs();
        run("chain", 20, used);
        chk("chain_cycles", 64'(used), 64'd6);

        // Backpressure toggling during a 5-word packet on port 3.
        reset_all();
        load_pkt(3, 5, 1);
        expect_words(3, 0, 5);
        drive_srcs();
        for (int c = 0; c < 14; c++) begin
            tx_dst_rdy = (c % 2 == 1);
            mirror_on  = (c >= 1);
            cyc();
        end
        mirror_on = 1'b0;
        tx_dst_rdy = 1'b1;
        chk("bp_transfers", 64'(nobs), 64'd5);

        // Port 1 masked until enabled in the middle of port 0's second packet.
        reset_all();
        port_en = 4'b1101;
        load_pkt(0, 3, 0);
        load_pkt(0, 3, 1);
        for (int p = 1; p < P; p++) load_pkt(p, 3, 0);
        expect_words(0, 0, 3);
        expect_words(2, 0, 3);
        expect_words(3, 0, 3);
        expect_words(0, 3, 3);
        expect_words(1, 0, 3);
        drive_srcs();
        used = 0;
        while (nobs < 15 && used < 60) begin
            cyc();
            used++;
            if (nobs == 10) port_en = 4'b1111;
        end
        chk("en_transfers", 64'(nobs), 64'd15);
        chk("en_cycles", 64'(used), 64'd20);

        // Reset during the second word of a 4-word packet on port 2.
        reset_all();
        load_pkt(2, 4, 2);
        expect_words(2, 0, 2);
        drive_srcs();
        cyc();
        cyc();
        chk("pre_reset_grant", 64'({busy, grant}), 64'({1'b1, 2'd2}));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("post_reset", 64'({tx_src_rdy, busy, grant}), 64'd0);
        chk("post_reset_transfers", 64'(nobs), 64'd2);
        expq.delete();
        nobs = 0;
        clear_srcs();
        load_pkt(0, 1, 5);
        load_pkt(1, 1, 5);
        expect_words(0, 0, 1);
        expect_words(1, 0, 1);
        drive_srcs();
        run("fresh", 20, used);
        chk("fresh_cycles", 64'(used), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flu_pfifo_sched.md
# flu_pfifo_sched

Packet-granular round-robin scheduler that merges PORTS FrameLinkUnaligned (FLU) streams, each typically the TX side of a flu_pfifo instance, onto one FLU output. Grant is taken only at packet start and held until the granted packet ends, so packets are never interleaved. The block sits between a bank of per-channel packet FIFOs and a shared downstream consumer such as a DMA or MAC TX.

## Interface
- PORTS, 4: number of FLU inputs, 2..16.
- DATA_WIDTH, 512: FLU data width in bits, power of two.
- SOP_POS_WIDTH, 3: SOP position width; SOP block size is DATA_WIDTH/2^SOP_POS_WIDTH bits.
- EOP_POS_WIDTH, log2(DATA_WIDTH/8): EOP byte position width.

- CLK  in  1  clock, all logic rising-edge.
- RESET  in  1  synchronous, active-high reset.
- RX_DATA  in  PORTS*DATA_WIDTH  input data; port i occupies slice i.
- RX_SOP_POS  in  PORTS*SOP_POS_WIDTH  per-port SOP block position.
- RX_EOP_POS  in  PORTS*EOP_POS_WIDTH  per-port EOP byte position.
- RX_SOP, RX_EOP, RX_SRC_RDY  in  PORTS  per-port FLU control.
- RX_DST_RDY  out  PORTS  per-port ready; at most one bit high.
- PORT_EN  in  PORTS  scheduling enable mask, sampled only at arbitration.
- TX_DATA  out  DATA_WIDTH  merged output data.
- TX_SOP_POS  out  SOP_POS_WIDTH  merged SOP block position.
- TX_EOP_POS  out  EOP_POS_WIDTH  merged EOP byte position.
- TX_SOP, TX_EOP, TX_SRC_RDY  out  1  merged FLU control.
- TX_DST_RDY  in  1  downstream ready.
- GRANT  out  log2(PORTS)  currently granted port index.
- BUSY  out  1  high in LOCKED state.

## Operation
- Request: req[i] = RX_SRC_RDY[i] & RX_SOP[i] & PORT_EN[i].
- A head word without SOP never requests. That is a protocol violation; the port stalls and there is no recovery.
- sop_byte = SOP_POS << (EOP_POS_WIDTH - SOP_POS_WIDTH).
- open_after is true when a word leaves a packet open after it:
  - (SOP & !EOP), or
  - (SOP & EOP & sop_byte > EOP_POS), or
  - (!SOP & !EOP).
- A word with EOP and no trailing SOP closes the packet. A word with EOP and a trailing SOP keeps the grant; the new packet continues on the same port.
- FSM states:
  - IDLE: any req → register grant = first requesting port after last_grant (round-robin, wrapping), go to LOCKED. No req → stay.
  - LOCKED: the granted port is muxed to TX. On a transfer (TX_SRC_RDY & TX_DST_RDY) of a closing word: last_grant ← GRANT, go to IDLE. Otherwise stay.
- Datapath is a combinational mux selected by the grant register.
  - TX_SRC_RDY = LOCKED & RX_SRC_RDY[g].
  - RX_DST_RDY[g] = LOCKED & TX_DST_RDY; all other ports get 0.
- PORT_EN changes and new requests mid-packet have no effect until the next IDLE.

## Timing
- Reset values:
  - state IDLE, GRANT 0, last_grant PORTS-1 (so port 0 wins first), BUSY 0.
  - TX_SRC_RDY 0, RX_DST_RDY all 0; TX_SOP/TX_EOP forced 0 while IDLE.
- Arbitration costs one IDLE cycle per packet chain. The first word of a granted packet appears on TX the cycle after IDLE sees the request.
- After arbitration, data latency RX→TX is 0 cycles. Backpressure TX_DST_RDY→RX_DST_RDY is combinational.
- Single-word packet (SOP & EOP, sop_byte ≤ EOP_POS): IDLE, LOCKED 1 cycle, IDLE. Peak single-port throughput is 1 packet per 2 cycles.
- TX_DST_RDY low on the closing word: stay LOCKED and hold all outputs stable.
- RESET asserted mid-packet: next cycle is IDLE with outputs at reset values. The partially sent packet is abandoned.

## Structure
- Package flu_sched_pkg holds:
  - the state enum (IDLE, LOCKED);
  - the sop_byte / open_after helper function;
  - the log2 constant function.
- Sub-module rr_arbiter(PORTS): combinational round-robin picker. Inputs are req and last_grant; outputs are grant index and valid. Reusable elsewhere.
- flu_pfifo_sched contains the FSM, the grant and last_grant registers, and the FLU mux.

## Test plan
- Reset then idle (all SRC_RDY=0): TX_SRC_RDY=0, BUSY=0, GRANT=0 for 20 cycles.
- Ports 0..3 each hold one 3-word packet, all requesting: output order is 0,1,2,3. Each packet is preceded by exactly one IDLE cycle and is never interleaved.
- Port 1 sends a word with EOP_POS=10, SOP=1, SOP_POS=2 (sop_byte 16), while port 2 requests: grant stays 1 until the next closing word, then moves to port 2.
- TX_DST_RDY toggles 0/1 every cycle during a 5-word packet on port 3: exactly 5 transfers, data matches byte-for-byte, RX_DST_RDY[3] mirrors TX_DST_RDY.
- PORT_EN=0b1101 with all ports requesting: port 1 is never granted. Setting PORT_EN[1]=1 mid-packet on port 0 gives port 1 the next grant.
- RESET pulse during the 2nd word of a 4-word packet: the next cycle shows TX_SRC_RDY=0, BUSY=0, GRANT=0, and a fresh packet on port 0 is accepted afterwards.
